// File: rtl/inst_fetch_bridge_pkg.sv
// Shared definitions for the dual-issue fetch bridge: NOP filler word,
// line-tag type, FSM state encoding and the line-buffer fill payload.
package inst_fetch_bridge_pkg;

  // An 8-byte line is identified by address bits [31:3].
  localparam int TAG_W = 32 - 3;

  // addi x0,x0,0 -- returned in both halves whenever the bundle is not ready.
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef logic [TAG_W-1:0] line_tag_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DEM_HI,
    ST_DEM_LO,
    ST_PF_HI,
    ST_PF_LO
  } fetch_state_t;

  // One complete line on its way into the buffers.
  typedef struct packed {
    line_tag_t   tag;
    logic [31:0] hi;   // word at line+0
    logic [31:0] lo;   // word at line+4
  } fill_t;

  // Prefetch states share the demand datapath; only abort handling differs.
  function automatic logic is_prefetch(input fetch_state_t s);
    return (s == ST_PF_HI) || (s == ST_PF_LO);
  endfunction

endpackage

// File: rtl/fetch_line_buf.sv
// Two-entry line buffer: hit compare for the current line and for line+1,
// LRU victim selection and a single write port for completed fills.
module fetch_line_buf
  import inst_fetch_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  line_tag_t   lookup_tag,
  input  line_tag_t   probe_tag,
  output logic        hit,
  output logic [63:0] hit_data,
  output logic        probe_hit,
  input  logic        wr_en,
  input  fill_t       wr_fill
);

  logic [1:0]  valid_q;
  logic        lru_q;
  line_tag_t   tag_q [2];
  logic [31:0] hi_q  [2];
  logic [31:0] lo_q  [2];

  logic [1:0]  hit_vec;
  logic [1:0]  probe_vec;
  logic [1:0]  wr_match;
  logic        hit_idx;
  logic        wr_idx;

  // Tag compares for lookup, next-line probe and write-target selection.
  always_comb begin
    // NOTE: every signal gets a default before the loop so no path leaves it unassigned (no latch).
    hit_vec   = '0;
    probe_vec = '0;
    wr_match  = '0;
    for (int i = 0; i < 2; i++) begin
      hit_vec[i]   = valid_q[i] && (tag_q[i] == lookup_tag);
      probe_vec[i] = valid_q[i] && (tag_q[i] == probe_tag);
      wr_match[i]  = valid_q[i] && (tag_q[i] == wr_fill.tag);
    end
  end

  assign hit       = |hit_vec;
  assign hit_idx   = hit_vec[1];
  assign probe_hit = |probe_vec;
  assign hit_data  = hit ? {hi_q[hit_idx], lo_q[hit_idx]} : {NOP_INST, NOP_INST};

  // A refill of a line already held overwrites that entry, never a duplicate.
  assign wr_idx = wr_match[0] ? 1'b0 : (wr_match[1] ? 1'b1 : lru_q);

  // Valid bits and LRU pointer: the only state that must be known after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
      valid_q <= '0;
      lru_q   <= 1'b0;
    end else begin
      if (wr_en) valid_q[wr_idx] <= 1'b1;
      if (hit)   lru_q <= ~hit_idx;
    end
  end

  // Line payload storage, written only by completed fills.
  // NOTE: payload has no reset; it is never observed unless its valid bit is set.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx] <= wr_fill.tag;
      hi_q[wr_idx]  <= wr_fill.hi;
      lo_q[wr_idx]  <= wr_fill.lo;
    end
  end

endmodule

// File: rtl/inst_fetch_bridge.sv
// Fetch-side responder: serves 64-bit bundles from two line buffers, fills
// misses and prefetches line+8 through a 32-bit single-outstanding memory.
module inst_fetch_bridge
  import inst_fetch_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] inst_addr_in,
  output logic [63:0] inst_out,
  output logic        stall_out,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  fetch_state_t state_q;
  line_tag_t    req_tag_q;
  logic [31:0]  hi_buf_q;

  line_tag_t    line_tag;
  line_tag_t    next_tag;
  logic         hit;
  logic         probe_hit;
  logic         pf_abort;
  logic         beat_done;
  logic         wr_en;
  fill_t        wr_fill;
  logic         addr_offset_unused;

  assign line_tag           = inst_addr_in[31:3];
  assign next_tag           = line_tag + line_tag_t'(1);
  assign addr_offset_unused = ^inst_addr_in[2:0];

  // A beat completes only when the ack lands on an outstanding request.
  assign beat_done = mem_req && mem_ack;

  // A prefetch is dropped when fetch has moved to some other missing line.
  assign pf_abort = !hit && (line_tag != req_tag_q);

  // Second beat of a fill that is not being discarded commits the line.
  assign wr_en   = beat_done && ((state_q == ST_DEM_LO) || (state_q == ST_PF_LO && !pf_abort));
  assign wr_fill = '{tag: req_tag_q, hi: hi_buf_q, lo: mem_rdata};

  fetch_line_buf u_line_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .lookup_tag (line_tag),
    .probe_tag  (next_tag),
    .hit        (hit),
    .hit_data   (inst_out),
    .probe_hit  (probe_hit),
    .wr_en      (wr_en),
    .wr_fill    (wr_fill)
  );

  assign stall_out = !hit;

  // Fill/prefetch sequencer; owns the registered memory request and address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      req_tag_q <= '0;
      hi_buf_q  <= '0;
      mem_req   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!hit) begin
            req_tag_q <= line_tag;
            mem_req   <= 1'b1;
            mem_addr  <= {line_tag, 3'b000};
            state_q   <= ST_DEM_HI;
          end else if (!probe_hit) begin
            req_tag_q <= next_tag;
            mem_req   <= 1'b1;
            mem_addr  <= {next_tag, 3'b000};
            state_q   <= ST_PF_HI;
          end
        end

        ST_DEM_HI, ST_PF_HI: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {req_tag_q, 3'b000};
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_prefetch(state_q) && pf_abort) begin
              req_tag_q <= line_tag;
              state_q   <= ST_DEM_HI;
            end else begin
              hi_buf_q <= mem_rdata;
              state_q  <= (state_q == ST_DEM_HI) ? ST_DEM_LO : ST_PF_LO;
            end
          end
        end

        ST_DEM_LO, ST_PF_LO: begin
          if (!mem_req) begin
            mem_req  <= 1'b1;
            mem_addr <= {req_tag_q, 3'b100};
          end else if (mem_ack) begin
            mem_req <= 1'b0;
            if (is_prefetch(state_q) && pf_abort) begin
              req_tag_q <= line_tag;
              state_q   <= ST_DEM_HI;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Self-checking bench: directed timing scenarios plus randomized fetch
// streams judged against a memory image and protocol/liveness rules.
module tb_inst_fetch_bridge;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [63:0] NOP_PAIR = {NOP, NOP};

  logic        clk;
  logic        rst_n;
  logic [31:0] inst_addr_in;
  logic [63:0] inst_out;
  logic        stall_out;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  int n_total = 0;
  int n_bad   = 0;

  int lat      = 1;   // cycles from request to ack, inclusive
  bit spurious = 0;   // pulse ack while no request is outstanding

  inst_fetch_bridge dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .inst_addr_in (inst_addr_in),
    .inst_out     (inst_out),
    .stall_out    (stall_out),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Instruction memory image: two fixed words, everything else hashed.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hAAAA_0001;
      32'h0000_0104: return 32'hBBBB_0002;
      default:       return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
    endcase
  endfunction

  function automatic logic [63:0] line_data(input logic [31:0] a);
    logic [31:0] base;
    base = {a[31:3], 3'b000};
    return {mem_word(base), mem_word(base + 32'd4)};
  endfunction

  // Memory responder: acks the lat-th cycle of each request.
  initial begin
    int wait_cnt;
    wait_cnt  = 0;
    mem_ack   = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_ack = 1'b0;
      if (mem_req) begin
        if (wait_cnt >= lat - 1) begin
          mem_ack   = 1'b1;
          mem_rdata = mem_word(mem_addr);
          wait_cnt  = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
        if (spurious && $urandom_range(0, 2) == 0) begin
          mem_ack   = 1'b1;
          mem_rdata = $urandom;
        end
      end
    end
  end

  // Continuous monitor: bundle content, reset outputs and handshake rules.
  initial begin
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        check("rst_stall", stall_out, 1);
        check("rst_bundle", inst_out, NOP_PAIR);
        check("rst_req", mem_req, 0);
        prev_req = 1'b0;
        prev_ack = 1'b0;
      end else begin
        check("bundle", inst_out, stall_out ? NOP_PAIR : line_data(inst_addr_in));
        if (mem_req) check("addr_align", mem_addr[1:0], 0);
        if (prev_req && !prev_ack) begin
          check("req_hold", mem_req, 1);
          check("addr_hold", mem_addr, prev_addr);
        end
        if (prev_req && prev_ack) check("req_gap", mem_req, 0);
        prev_req  = mem_req;
        prev_ack  = mem_ack;
        prev_addr = mem_addr;
      end
    end
  end

  // Advance one cycle; registered outputs and ack are settled on return.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Reset for 3 cycles with the given PC; returns inside the first free cycle.
  task automatic do_reset(input logic [31:0] addr);
    @(posedge clk);
    #2;
    rst_n        = 1'b0;
    inst_addr_in = addr;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  // Wait until the current PC is served, with a bounded budget.
  task automatic wait_hit(input string tag);
    int n;
    n = 0;
    while (stall_out && n < 60) begin
      cyc();
      n++;
    end
    check(tag, stall_out, 0);
  endtask

  // Wait for the next rising request and report its address.
  task automatic next_req(input string tag, output logic [31:0] addr);
    int n;
    n = 0;
    while (mem_req && n < 60) begin
      cyc();
      n++;
    end
    while (!mem_req && n < 60) begin
      cyc();
      n++;
    end
    check(tag, mem_req, 1);
    addr = mem_addr;
  endtask

  // Cold demand fill with a 1-cycle memory: exact cycle-by-cycle expectations.
  task automatic demand_timing(input logic [31:0] line);
    cyc();
    check("dem_c1_req", mem_req, 1);
    check("dem_c1_addr", mem_addr, line);
    check("dem_c1_stall", stall_out, 1);
    cyc();
    check("dem_c2_req", mem_req, 0);
    cyc();
    check("dem_c3_req", mem_req, 1);
    check("dem_c3_addr", mem_addr, line + 32'd4);
    check("dem_c3_stall", stall_out, 1);
    cyc();
    check("dem_c4_stall", stall_out, 0);
    check("dem_c4_bundle", inst_out, line_data(line));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] pc;
    rst_n        = 1'b0;
    inst_addr_in = '0;

    // Reset and first fill at line 0.
    lat = 1;
    do_reset(32'h0);
    demand_timing(32'h0);

    // Cold miss at 0x100 followed by next-line prefetch.
    do_reset(32'h0000_0103);
    demand_timing(32'h100);
    check("cold_bundle", inst_out, 64'hAAAA0001_BBBB0002);
    cyc();
    check("pf_c5_req", mem_req, 1);
    check("pf_c5_addr", mem_addr, 32'h108);
    cyc();
    cyc();
    check("pf_c7_req", mem_req, 1);
    check("pf_c7_addr", mem_addr, 32'h10C);
    cyc();
    inst_addr_in = 32'h108;
    #1;
    check("pf_seq_stall", stall_out, 0);
    check("pf_seq_bundle", inst_out, line_data(32'h108));

    // Branch to 0x200 while the prefetch of 0x108 is outstanding.
    do_reset(32'h100);
    demand_timing(32'h100);
    lat = 3;
    cyc();
    check("br_pf_addr", mem_addr, 32'h108);
    inst_addr_in = 32'h200;
    #1;
    check("br_stall", stall_out, 1);
    next_req("br_req_seen", a);
    check("br_next_addr", a, 32'h200);
    wait_hit("br_fill_done");
    check("br_bundle", inst_out, line_data(32'h200));
    inst_addr_in = 32'h108;
    #1;
    check("br_pf_discarded", stall_out, 1);
    inst_addr_in = 32'h100;
    #1;
    check("br_old_kept", stall_out, 0);
    check("br_old_bundle", inst_out, 64'hAAAA0001_BBBB0002);

    // Prefetch of the line after 0xFFFF_FFF8 wraps to 0.
    lat = 1;
    do_reset(32'hFFFF_FFF8);
    demand_timing(32'hFFFF_FFF8);
    cyc();
    check("wrap_hi_req", mem_req, 1);
    check("wrap_hi_addr", mem_addr, 32'h0);
    cyc();
    cyc();
    check("wrap_lo_req", mem_req, 1);
    check("wrap_lo_addr", mem_addr, 32'h4);

    // Slow memory with stray acks in the gaps.
    lat = 6;
    do_reset(32'h300);
    spurious = 1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("slow_req", mem_req, 1);
      check("slow_addr", mem_addr, 32'h300);
    end
    wait_hit("slow_fill_done");
    check("slow_bundle", inst_out, line_data(32'h300));
    spurious = 0;

    // Randomized fetch streams: sequential runs, branches, wrap region.
    lat = 1;
    do_reset(32'h0);
    pc = 32'h0;
    for (int seg = 0; seg < 8; seg++) begin
      lat      = $urandom_range(1, 4);
      spurious = ($urandom_range(0, 1) == 1);
      for (int n = 0; n < 20; n++) begin
        case ($urandom_range(0, 3))
          0:       pc = {pc[31:3], 3'b000} + 32'd8;
          1:       pc = 32'h0000_0100 + 32'($urandom_range(0, 5)) * 32'd8;
          2:       pc = $urandom;
          default: pc = 32'hFFFF_FFE0 + 32'($urandom_range(0, 3)) * 32'd8;
        endcase
        pc[2:0]      = 3'($urandom_range(0, 7));
        inst_addr_in = pc;
        repeat ($urandom_range(1, 8)) cyc();
        if ($urandom_range(0, 2) == 0) wait_hit("rand_live");
      end
    end
    spurious = 0;
    repeat (4) cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", n_total, n_bad);
    $fatal(1);
  end

endmodule
